div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider for the execute stage: restoring radix-2, one step per cycle.
// Compile option: DIV_EARLY_EXIT_EN skips the iteration for zero divisors and |dividend| < |divisor|.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_valid,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        flush,
    output logic        div_block,
    output logic        div_done,
    output logic [31:0] div_q,
    output logic [31:0] div_r
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  cnt_q;
    logic [63:0] sr_q;
    logic [63:0] sr_step;
    logic [31:0] dvs_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dvz_q;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        accept;
    logic        early;
    logic        last_step;
    logic [32:0] trial;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign mag1   = (div_signed && div_src1[31]) ? (32'd0 - div_src1) : div_src1;
    assign mag2   = (div_signed && div_src2[31]) ? (32'd0 - div_src2) : div_src2;
    assign accept = (state_q == IDLE) && div_valid && !flush;

`ifdef DIV_EARLY_EXIT_EN
    assign early = (div_src2 == '0) || (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    assign last_step = (state_q == BUSY) && (cnt_q == 6'd31) && !flush;

    // Partial remainder is below the divisor, so the shifted trial value fits in 33 bits
    // and bit 32 of the difference is exactly the borrow.
    assign trial   = sr_q[63:31] - {1'b0, dvs_q};
    assign sr_step = trial[32] ? {sr_q[62:0], 1'b0}
                               : {trial[31:0], sr_q[30:0], 1'b1};

    // Divide-by-zero yields an all-ones quotient; the remainder is already |src1| and
    // the dividend-sign fix restores the original dividend.
    assign q_fix = dvz_q   ? '1
                 : q_neg_q ? (32'd0 - sr_step[31:0]) : sr_step[31:0];
    assign r_fix = r_neg_q ? (32'd0 - sr_step[63:32]) : sr_step[63:32];

    assign div_done  = (state_q == DONE) && !flush;
    assign div_block = div_valid && !div_done && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = early ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dvz_q   <= 1'b0;
            div_q   <= '0;
            div_r   <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            sr_q    <= {32'd0, mag1};
            dvs_q   <= mag2;
            q_neg_q <= div_signed && (div_src1[31] ^ div_src2[31]);
            r_neg_q <= div_signed && div_src1[31];
            dvz_q   <= (div_src2 == '0);
            if (early) begin
                div_q <= (div_src2 == '0) ? '1 : '0;
                div_r <= div_src1;
            end
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 6'd1;
            sr_q  <= sr_step;
            if (last_step) begin
                div_q <= q_fix;
                div_r <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, multi-cycle corner sequences and random operations.
module tb_div_unit;

`ifdef DIV_EARLY_EXIT_EN
    localparam int EL = 1;
`else
    localparam int EL = 33;
`endif

    logic        clk;
    logic        resetn;
    logic        div_valid;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        flush;
    logic        div_block;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;

    int tests;
    int fails;

    div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .div_valid (div_valid),
        .div_signed(div_signed),
        .div_src1  (div_src1),
        .div_src2  (div_src2),
        .flush     (flush),
        .div_block (div_block),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer division on 64-bit values, so the signed overflow case wraps naturally.
    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, qq, rr, ma, mb;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[31:0];
            r  = rr[31:0];
        end
        lat = (b == 32'd0 || ma < mb) ? EL : 33;
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the operation.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q_exp, input logic [31:0] r_exp, input int lat_exp,
                          input string name, input bit keep, input bit scramble);
        int cyc;
        bit got;
        bit blk_ok;
        div_valid  = 1'b1;
        div_signed = sgn;
        div_src1   = a;
        div_src2   = b;
        cyc    = 0;
        got    = 0;
        blk_ok = 1;
        while (!got && cyc <= 100) begin
            @(negedge clk);
            if (div_done) begin
                got = 1;
            end else begin
                if (div_block !== 1'b1) blk_ok = 0;
                @(posedge clk);
                #1;
                cyc++;
                if (scramble) begin
                    div_src1 = $urandom;
                    div_src2 = $urandom;
                end
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout actual=no_done expected=done_in_%0d", name, lat_exp);
        end else begin
            chk({name, "_lat"}, cyc, lat_exp);
            chk({name, "_q"}, div_q, q_exp);
            chk({name, "_r"}, div_r, r_exp);
            chk({name, "_blk_done"}, {31'd0, div_block}, 32'd0);
        end
        chk({name, "_blk_busy"}, {31'd0, blk_ok}, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) begin
            div_valid = 1'b0;
            @(negedge clk);
            chk({name, "_pulse"}, {31'd0, div_done}, 32'd0);
            chk({name, "_hold_q"}, div_q, q_exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic watch_no_done(input string name, input int n);
        bit seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (div_done) seen = 1;
        end
        chk(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs;
        int          rl;

        tests      = 0;
        fails      = 0;
        resetn     = 1'b0;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        div_src1   = '0;
        div_src2   = '0;
        flush      = 1'b0;

        vt[0] = '{1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002, 33};
        vt[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vt[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, 33};
        vt[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF, 32'h0000_0005, EL};
        vt[4] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFB, EL};
        vt[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 32'h0000_0000, 33};
        vt[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001, 33};
        vt[7] = '{1'b0, 32'd3,          32'd10,         32'h0000_0000, 32'h0000_0003, EL};
        vt[8] = '{1'b1, 32'hFFFF_FFFD,  32'd10,         32'h0000_0000, 32'hFFFF_FFFD, EL};
        vt[9] = '{1'b0, 32'd0,          32'd5,          32'h0000_0000, 32'h0000_0000, EL};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", div_q, 32'd0);
        chk("rst_r", div_r, 32'd0);
        chk("rst_done", {31'd0, div_done}, 32'd0);
        chk("rst_block", {31'd0, div_block}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            do_div(vt[i].sgn, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].lat,
                   $sformatf("vec%0d", i), 1'b0, 1'b0);
        end

        do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, "b2b_first", 1'b1, 1'b0);
        do_div(1'b0, 32'd10, 32'd4, 32'd2, 32'd2, 33, "b2b_second", 1'b0, 1'b0);

        // Flush in cycle 10 of a DIVU; previous results (2, 2) must survive.
        div_valid  = 1'b1;
        div_signed = 1'b0;
        div_src1   = 32'd1000;
        div_src2   = 32'd3;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_blk", {31'd0, div_block}, 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        div_valid = 1'b0;
        @(negedge clk);
        chk("flush_q", div_q, 32'd2);
        chk("flush_r", div_r, 32'd2);
        chk("flush_blk_after", {31'd0, div_block}, 32'd0);
        watch_no_done("flush_no_done", 40);

        // Flush coinciding with a new request wins.
        @(posedge clk);
        #1;
        div_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        flush     = 1'b0;
        watch_no_done("flush_prio_no_done", 40);

        // Reset in cycle 20 of a signed divide.
        @(posedge clk);
        #1;
        div_valid  = 1'b1;
        div_signed = 1'b1;
        div_src1   = 32'hFFFF_FF9C;
        div_src2   = 32'd7;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        #1;
        chk("midrst_q", div_q, 32'd0);
        chk("midrst_r", div_r, 32'd0);
        chk("midrst_done", {31'd0, div_done}, 32'd0);
        @(negedge clk);
        div_valid = 1'b0;
        resetn    = 1'b1;
        watch_no_done("midrst_no_done", 40);
        @(posedge clk);
        #1;
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, "after_rst", 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = $urandom_range(0, 255);
                4: begin ra = $urandom_range(0, 1000); rb = 32'hFFFF_FFFF - $urandom_range(0, 1000); end
                default: ;
            endcase
            ref_div(rs, ra, rb, rq, rr, rl);
            do_div(rs, ra, rb, rq, rr, rl, $sformatf("rnd%0d", n), 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
